// File: rtl/jpeg_dht_parser_pkg.sv
// Shared types and limits for the JPEG DHT (Huffman table) segment parser.
package jpeg_dht_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_H  = 3'd1,
    LEN_L  = 3'd2,
    TCTH   = 3'd3,
    COUNTS = 3'd4,
    VALUES = 3'd5,
    FIN    = 3'd6,
    ERR    = 3'd7
  } dht_state_e;

  localparam int unsigned DC_MAX_SYMS = 12;
  localparam int unsigned AC_MAX_SYMS = 162;

  localparam logic [1:0] YDC = 2'd0;
  localparam logic [1:0] YAC = 2'd1;
  localparam logic [1:0] CDC = 2'd2;
  localparam logic [1:0] CAC = 2'd3;

  function automatic logic [11:0] max_syms(input logic tc);
    return tc ? 12'(AC_MAX_SYMS) : 12'(DC_MAX_SYMS);
  endfunction

endpackage

// File: rtl/jpeg_dht_parser_if.sv
// Byte-stream input plus count/value write ports of the DHT parser.
interface jpeg_dht_parser_if;
  logic       Start;
  logic       DataInEnable;
  logic [7:0] DataIn;
  logic       DataInRead;
  logic       DhtEnable;
  logic [1:0] DhtColor;
  logic [7:0] DhtCount;
  logic [7:0] DhtData;
  logic       CntEnable;
  logic [1:0] CntColor;
  logic [3:0] CntIndex;
  logic [7:0] CntData;
  logic       Busy;
  logic       Done;
  logic       Error;

  modport slave (
    input  Start, DataInEnable, DataIn,
    output DataInRead, DhtEnable, DhtColor, DhtCount, DhtData,
           CntEnable, CntColor, CntIndex, CntData, Busy, Done, Error
  );

  modport master (
    output Start, DataInEnable, DataIn,
    input  DataInRead, DhtEnable, DhtColor, DhtCount, DhtData,
           CntEnable, CntColor, CntIndex, CntData, Busy, Done, Error
  );
endinterface

// File: rtl/jpeg_dht_parser.sv
// Parses a DHT segment body (after FF C4) and streams code-length counts and
// symbol values out as registered write strobes.
//
// state  | meaning
// IDLE   | waiting for Start
// LEN_H  | expecting length high byte
// LEN_L  | expecting length low byte
// TCTH   | expecting table class / id byte
// COUNTS | expecting the 16 code-length counts
// VALUES | expecting sum symbol values
// FIN    | segment complete, Done pulse
// ERR    | malformed segment, holds until Start
module jpeg_dht_parser
  import jpeg_dht_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  jpeg_dht_parser_if.slave  io_dht
);

  dht_state_e  r_state;
  dht_state_e  w_next_state;

  logic [7:0]  r_len_h;
  logic [15:0] r_remaining;
  logic        r_tc;
  logic        r_th;
  logic [3:0]  r_cnt_idx;
  logic [11:0] r_sum;
  logic [7:0]  r_val_idx;

  logic        r_cnt_en;
  logic [1:0]  r_cnt_color;
  logic [3:0]  r_cnt_index;
  logic [7:0]  r_cnt_data;
  logic        r_dht_en;
  logic [1:0]  r_dht_color;
  logic [7:0]  r_dht_count;
  logic [7:0]  r_dht_data;

  logic        w_read;
  logic        w_accept;
  logic [15:0] w_len;
  logic [15:0] w_rem_dec;
  logic [11:0] w_sum_next;
  logic        w_tcth_bad;
  logic        w_last_value;

  always_comb begin
    w_read       = (r_state == LEN_H) || (r_state == LEN_L) || (r_state == TCTH) ||
                   (r_state == COUNTS) || (r_state == VALUES);
    w_accept     = io_dht.DataInEnable & w_read;
    w_len        = {r_len_h, io_dht.DataIn};
    w_rem_dec    = r_remaining - 16'd1;
    w_sum_next   = r_sum + 12'(io_dht.DataIn);
    w_tcth_bad   = (|io_dht.DataIn[7:5]) | (|io_dht.DataIn[3:1]);
    w_last_value = (({4'b0, r_val_idx} + 12'd1) == r_sum);
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:   if (io_dht.Start) w_next_state = LEN_H;
      LEN_H:  if (w_accept) w_next_state = LEN_L;
      LEN_L:
        if (w_accept) begin
          if (w_len < 16'd2)       w_next_state = ERR;
          else if (w_len == 16'd2) w_next_state = FIN;
          else                     w_next_state = TCTH;
        end
      TCTH:
        if (w_accept) begin
          // the table byte must leave room for at least one count
          if (w_tcth_bad || (w_rem_dec == 16'd0)) w_next_state = ERR;
          else                                    w_next_state = COUNTS;
        end
      COUNTS:
        if (w_accept) begin
          if (r_cnt_idx == 4'd15) begin
            if ((w_sum_next > max_syms(r_tc)) || ({4'b0, w_sum_next} > w_rem_dec))
              w_next_state = ERR;
            else if (w_sum_next != 12'd0)
              w_next_state = VALUES;
            else if (w_rem_dec == 16'd0)
              w_next_state = FIN;
            else
              w_next_state = TCTH;
          end else if (w_rem_dec == 16'd0) begin
            w_next_state = ERR;
          end
        end
      VALUES:
        if (w_accept) begin
          if (w_last_value)             w_next_state = (w_rem_dec == 16'd0) ? FIN : TCTH;
          else if (w_rem_dec == 16'd0)  w_next_state = ERR;
        end
      FIN:    w_next_state = IDLE;
      ERR:    if (io_dht.Start) w_next_state = LEN_H;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_len_h     <= '0;
      r_remaining <= '0;
      r_tc        <= 1'b0;
      r_th        <= 1'b0;
      r_cnt_idx   <= '0;
      r_sum       <= '0;
      r_val_idx   <= '0;
      r_cnt_en    <= 1'b0;
      r_cnt_color <= '0;
      r_cnt_index <= '0;
      r_cnt_data  <= '0;
      r_dht_en    <= 1'b0;
      r_dht_color <= '0;
      r_dht_count <= '0;
      r_dht_data  <= '0;
    end else begin
      r_cnt_en <= 1'b0;
      r_dht_en <= 1'b0;
      if (w_accept) begin
        case (r_state)
          LEN_H: r_len_h <= io_dht.DataIn;
          LEN_L: r_remaining <= w_len - 16'd2;
          TCTH: begin
            r_remaining <= w_rem_dec;
            r_tc        <= io_dht.DataIn[4];
            r_th        <= io_dht.DataIn[0];
            r_cnt_idx   <= '0;
            r_sum       <= '0;
          end
          COUNTS: begin
            r_remaining <= w_rem_dec;
            r_cnt_idx   <= r_cnt_idx + 4'd1;
            r_sum       <= w_sum_next;
            r_val_idx   <= '0;
            r_cnt_en    <= 1'b1;
            r_cnt_color <= {r_th, r_tc};
            r_cnt_index <= r_cnt_idx;
            r_cnt_data  <= io_dht.DataIn;
          end
          VALUES: begin
            r_remaining <= w_rem_dec;
            r_val_idx   <= r_val_idx + 8'd1;
            r_dht_en    <= 1'b1;
            r_dht_color <= {r_th, r_tc};
            r_dht_count <= r_val_idx;
            r_dht_data  <= io_dht.DataIn;
          end
          default: ;
        endcase
      end
    end
  end

  assign io_dht.DataInRead = w_read;
  assign io_dht.Busy       = (r_state != IDLE) && (r_state != ERR);
  assign io_dht.Done       = (r_state == FIN);
  assign io_dht.Error      = (r_state == ERR);
  assign io_dht.CntEnable  = r_cnt_en;
  assign io_dht.CntColor   = r_cnt_color;
  assign io_dht.CntIndex   = r_cnt_index;
  assign io_dht.CntData    = r_cnt_data;
  assign io_dht.DhtEnable  = r_dht_en;
  assign io_dht.DhtColor   = r_dht_color;
  assign io_dht.DhtCount   = r_dht_count;
  assign io_dht.DhtData    = r_dht_data;

endmodule

// File: tb/tb_jpeg_dht_parser.sv
// Bench for jpeg_dht_parser: directed segments plus random segments checked
// against a byte-level DHT parsing model.
module tb_jpeg_dht_parser;

  logic clk;
  logic rst;
  jpeg_dht_parser_if bus();

  jpeg_dht_parser dut (.clk(clk), .rst(rst), .io_dht(bus.slave));

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  seg[$];
  logic [13:0] exp_cnt[$], got_cnt[$];
  logic [17:0] exp_dht[$], got_dht[$];
  int          exp_done;
  bit          exp_err;
  int          done_cnt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (bus.CntEnable) got_cnt.push_back({bus.CntColor, bus.CntIndex, bus.CntData});
    if (bus.DhtEnable) got_dht.push_back({bus.DhtColor, bus.DhtCount, bus.DhtData});
    if (bus.Done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({bus.DataInRead, bus.DhtEnable, bus.DhtColor, bus.DhtCount, bus.DhtData,
                bus.CntEnable, bus.CntColor, bus.CntIndex, bus.CntData,
                bus.Busy, bus.Done, bus.Error});
  endfunction

  // Byte-level parse of seg: what a correct parser must write and how it ends.
  task automatic model();
    int          p;
    int unsigned L, rem, sum;
    logic [3:0]  tc, th;
    logic [1:0]  col;
    logic [7:0]  b;
    exp_cnt.delete();
    exp_dht.delete();
    exp_done = 0;
    exp_err  = 0;
    L = {seg[0], seg[1]};
    p = 2;
    if (L < 2) begin exp_err = 1; return; end
    rem = L - 2;
    while (rem > 0) begin
      b = seg[p]; p++; rem--;
      tc = b[7:4]; th = b[3:0];
      if (tc > 1 || th > 1 || rem == 0) begin exp_err = 1; return; end
      col = {th[0], tc[0]};
      sum = 0;
      for (int k = 0; k < 16; k++) begin
        b = seg[p]; p++; rem--;
        exp_cnt.push_back({col, 4'(k), b});
        sum += b;
        if (k < 15 && rem == 0) begin exp_err = 1; return; end
      end
      if (sum > ((tc == 1) ? 162 : 12) || sum > rem) begin exp_err = 1; return; end
      for (int n = 0; n < int'(sum); n++) begin
        b = seg[p]; p++; rem--;
        exp_dht.push_back({col, 8'(n), b});
      end
    end
    exp_done = 1;
  endtask

  task automatic do_reset();
    bus.Start = 1'b0;
    bus.DataInEnable = 1'b0;
    bus.DataIn = 8'h00;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive(input bit throttle, input bit mid_start, output bit to);
    int i = 0;
    int cyc = 0;
    bit en_v, rdy;
    to = 0;
    @(negedge clk);
    bus.Start = 1'b1;
    bus.DataInEnable = 1'b0;
    @(negedge clk);
    bus.Start = 1'b0;
    forever begin
      if (!bus.Busy) break;
      if (cyc >= 4000) begin to = 1; break; end
      en_v = (i < seg.size()) && (!throttle || $urandom_range(0, 2) != 0);
      bus.DataInEnable = en_v;
      bus.DataIn = en_v ? seg[i] : 8'($urandom);
      bus.Start = mid_start && (i == 4);
      #1 rdy = bus.DataInRead;
      @(negedge clk);
      if (en_v && rdy) i++;
      cyc++;
    end
    bus.DataInEnable = 1'b0;
    bus.Start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic run_seg(input string tag, input bit throttle, input bit mid_start);
    bit to;
    int n;
    model();
    got_cnt.delete();
    got_dht.delete();
    done_cnt = 0;
    drive(throttle, mid_start, to);
    chk({tag, "/timeout"}, 64'(to), 64'(0));
    chk({tag, "/ncnt"}, 64'(got_cnt.size()), 64'(exp_cnt.size()));
    n = (got_cnt.size() < exp_cnt.size()) ? got_cnt.size() : exp_cnt.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s/cnt%0d", tag, i), 64'(got_cnt[i]), 64'(exp_cnt[i]));
    chk({tag, "/ndht"}, 64'(got_dht.size()), 64'(exp_dht.size()));
    n = (got_dht.size() < exp_dht.size()) ? got_dht.size() : exp_dht.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s/dht%0d", tag, i), 64'(got_dht[i]), 64'(exp_dht[i]));
    chk({tag, "/done"}, 64'(done_cnt), 64'(exp_done));
    chk({tag, "/error"}, 64'(bus.Error), 64'(exp_err));
    chk({tag, "/rdy_end"}, 64'(bus.DataInRead), 64'(0));
  endtask

  task automatic gen_seg(input int mode);
    logic [7:0]  body[$];
    int          ntab, sum, maxs;
    int          cnts[16];
    logic        tc, th;
    int unsigned L;
    ntab = $urandom_range(1, 3);
    for (int t = 0; t < ntab; t++) begin
      tc = 1'($urandom_range(0, 1));
      th = 1'($urandom_range(0, 1));
      if (mode == 2 && t == 0) tc = 1'b0;
      maxs = tc ? 30 : 12;
      sum = (mode == 2 && t == 0) ? 13 : $urandom_range(0, maxs);
      if (mode == 1 && t == 0)
        body.push_back({4'($urandom_range(2, 15)), 4'($urandom_range(0, 15))});
      else
        body.push_back({3'b000, tc, 3'b000, th});
      foreach (cnts[k]) cnts[k] = 0;
      for (int j = 0; j < sum; j++) cnts[$urandom_range(0, 15)]++;
      for (int k = 0; k < 16; k++) body.push_back(8'(cnts[k]));
      for (int j = 0; j < sum; j++) body.push_back(8'($urandom));
    end
    L = body.size() + 2;
    if (mode == 3) L = L - $urandom_range(1, 6);
    if (mode == 4) L = $urandom_range(0, 1);
    seg.delete();
    seg.push_back(L[15:8]);
    seg.push_back(L[7:0]);
    foreach (body[k]) seg.push_back(body[k]);
  endtask

  task automatic luma_dc_seg();
    seg = '{8'h00, 8'h1F, 8'h00,
            8'h00, 8'h01, 8'h05, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01,
            8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int v = 0; v < 12; v++) seg.push_back(8'(v));
  endtask

  initial begin
    int cyc, i, mode;
    bit rdy;
    done_cnt = 0;
    do_reset();
    chk("reset/outs", all_outs(), 64'(0));

    luma_dc_seg();
    run_seg("luma_dc", 0, 0);
    chk("luma_dc/n12", 64'(got_dht.size()), 64'(12));
    if (got_dht.size() == 12) chk("luma_dc/last", 64'(got_dht[11]), 64'({2'b00, 8'd11, 8'd11}));

    seg = '{8'h00, 8'h27, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h3C,
            8'h11, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'hA2};
    run_seg("two_tab", 1, 0);
    if (got_dht.size() == 3) begin
      chk("two_tab/col0", 64'(got_dht[0][17:16]), 64'(2'b10));
      chk("two_tab/col1", 64'(got_dht[1][17:16]), 64'(2'b11));
      chk("two_tab/cnt_restart", 64'(got_dht[1][15:8]), 64'(0));
    end

    seg = '{8'h00, 8'h13, 8'h21, 8'h01, 8'h00};
    run_seg("bad_tcth", 0, 0);
    chk("bad_tcth/ncnt0", 64'(got_cnt.size()), 64'(0));
    @(negedge clk);
    bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    chk("bad_tcth/err_clr", 64'(bus.Error), 64'(0));
    chk("bad_tcth/busy", 64'(bus.Busy), 64'(1));
    do_reset();

    seg = '{8'h00, 8'h25, 8'h00, 8'h00, 8'h02, 8'h05, 8'h06, 8'h00, 8'h00, 8'h00,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_seg("dc_sum13", 0, 0);
    chk("dc_sum13/ndht0", 64'(got_dht.size()), 64'(0));

    seg = '{8'h00, 8'h13, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h05};
    run_seg("sum_gt_rem", 0, 0);

    seg = '{8'h00, 8'h02};
    run_seg("empty", 0, 0);
    seg = '{8'h00, 8'h01};
    run_seg("l_lt2", 0, 0);
    do_reset();

    for (int r = 0; r < 40; r++) begin
      mode = $urandom_range(0, 9);
      mode = (mode <= 5) ? 0 : mode - 5;
      gen_seg(mode);
      run_seg($sformatf("rnd%0d_m%0d", r, mode), 0, (r % 5) == 2);
      run_seg($sformatf("rnd%0d_m%0d_thr", r, mode), 1, 0);
    end

    luma_dc_seg();
    got_dht.delete();
    @(negedge clk);
    bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    i = 0;
    cyc = 0;
    while (got_dht.size() < 3 && cyc < 200) begin
      bus.DataInEnable = 1'b1;
      bus.DataIn = seg[i];
      #1 rdy = bus.DataInRead;
      @(negedge clk);
      if (rdy) i++;
      cyc++;
    end
    chk("rst_mid/reached", 64'(cyc < 200), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid/outs", all_outs(), 64'(0));
    rst = 1'b0;
    bus.DataInEnable = 1'b0;
    run_seg("after_rst", 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jpeg_dht_parser.md
JPEG_DHT_PARSER -- requirements
Module: jpeg_dht_parser

Interface
REQ-001 Port list, clock and reset first (name, direction, width, meaning):
  clk  in  1  sole clock, all logic on rising edge
  rst  in  1  synchronous, active-high reset
  Start  in  1  one-cycle pulse; the FF C4 marker was consumed upstream and the next byte is Lh
  DataInEnable  in  1  input byte valid
  DataIn  in  8  DHT segment byte
  DataInRead  out  1  ready; a byte is accepted when DataInEnable & DataInRead
  DhtEnable  out  1  symbol-value write strobe to the DHT store
  DhtColor  out  2  {Th[0], Tc[0]}: 00 Ydc, 01 Yac, 10 Cdc, 11 Cac
  DhtCount  out  8  symbol index within the table, 0-based
  DhtData  out  8  symbol value (run/size)
  CntEnable  out  1  code-length-count write strobe
  CntColor  out  2  same encoding as DhtColor
  CntIndex  out  4  code length minus 1 (0..15)
  CntData  out  8  number of codes of that length
  Busy  out  1  segment parse in progress
  Done  out  1  one-cycle pulse; segment parsed without error
  Error  out  1  sticky until the next Start or rst
REQ-002 One clock and one reset: clk, rst. Reset is synchronous and active-high.

Function
REQ-003 The FSM states are IDLE, LEN_H, LEN_L, TCTH, COUNTS, VALUES, FIN and ERR.
REQ-004 Transitions:
  - IDLE -> LEN_H on Start.
  - Each parse state advances only on an accepted byte.
  - LEN_L -> TCTH.
  - TCTH -> COUNTS.
  - COUNTS -> VALUES after 16 bytes, or -> TCTH/FIN if the sum is 0.
  - VALUES -> TCTH if remaining > 0, -> FIN if remaining = 0.
  - FIN -> IDLE after one cycle, with Done asserted in that cycle.
REQ-005 DataInRead is 1 only in LEN_H, LEN_L, TCTH, COUNTS and VALUES. At most one byte is accepted per cycle.
REQ-006 Remaining (16 bits) is loaded with L-2 after LEN_L and decrements by 1 on every accepted byte from TCTH onward.
REQ-007 In TCTH: Tc = DataIn[7:4] and Th = DataIn[3:0]. Tc > 1 or Th > 1 -> ERR.
REQ-008 In COUNTS: byte k (k = 0..15) produces a CntEnable write with CntIndex = k and CntData = byte. A 12-bit sum accumulates all 16 counts.
REQ-009 After the 16th count, ERR if any of the following holds:
  - sum > 12 for DC, or sum > 162 for AC;
  - sum > remaining.
REQ-010 In VALUES: the n-th accepted byte (n from 0) produces a DhtEnable write with DhtCount = n, DhtData = byte and DhtColor = {Th[0], Tc[0]}. VALUES exits after exactly sum bytes.
REQ-011 All write outputs (Dht*, Cnt*) are registered, asserted exactly 1 cycle after the accepting edge, and 0 (strobes) in every other cycle.
REQ-012 Length violations -> ERR:
  - L < 2;
  - remaining reaches 0 while in TCTH or COUNTS;
  - remaining reaches 0 before VALUES completes.
REQ-013 L = 2 (an empty segment) goes LEN_L -> FIN directly.
REQ-014 Multiple tables in one segment are parsed back-to-back. Each table restarts its DhtCount and CntIndex at 0.
REQ-015 ERR behaviour:
  - ERR drops DataInRead and raises Error;
  - no further writes occur;
  - ERR holds until Start or rst.
  Start in ERR clears Error and goes to LEN_H.
REQ-016 Start received while Busy is ignored.
REQ-017 Busy = 1 in every state except IDLE and ERR.

Reset
REQ-018 rst (synchronous) forces IDLE, zeroes every output, counter and register (DataInRead = 0, Error = 0), and aborts any parse mid-segment. Writes already issued are not undone.

Structure
REQ-019 Package jpeg_dht_pkg holds:
  - the state encoding;
  - DC_MAX_SYMS = 12 and AC_MAX_SYMS = 162;
  - the color codes YDC = 0, YAC = 1, CDC = 2, CAC = 3.
REQ-020 No sub-module; single FSM plus counters. The Dht* outputs connect directly to the DHT store's write port.
REQ-021 The target size is 150-300 lines of RTL.

Verification
REQ-022 Luma DC table:
  - Stimulus: Start, then 00 1F 00, counts 00 01 05 01 01 01 01 01 01 00 00 00 00 00 00 00, values 00..0B.
  - Response: 16 Cnt writes (color 00), 12 Dht writes (DhtCount 0..11 = data 0..11), one Done pulse; Error stays 0.
REQ-023 Two tables in one segment:
  - Stimulus: L = 0x0027, Cdc (TcTh = 01) with 1 symbol, then Cac (TcTh = 11) with 2 symbols.
  - Response: DhtColor 10 then 11, DhtCount restarts at 0, Done asserted once.
REQ-024 Bad TcTh: TcTh = 0x21 -> Error = 1, no Cnt or Dht writes, DataInRead = 0; a later Start clears Error.
REQ-025 Overflow:
  - DC counts summing to 13 -> Error after the 16th count, no Dht writes.
  - L = 0x0013 with sum = 1 -> Error (sum exceeds remaining).
REQ-026 Backpressure and reset:
  - DataInEnable toggled randomly -> write stream identical to the unthrottled run.
  - rst asserted mid-VALUES -> all outputs 0 next cycle; a fresh Start parses correctly.
